interrupt_priority_sequencer: RTL and testbench
===============================================

# interrupt_priority_sequencer

Interrupt arbitration and acknowledge sequencer for the 8259 PIC. It captures the IR0–IR7 request lines into the IRR and arbitrates among unmasked requests against the ISR, using fully nested priority with optional rotation. It runs the two-pulse INTA sequence that sets the ISR and delivers the 8-bit vector, and applies OCW2 EOI and rotate commands. It sits beside the ICW/OCW controller, which supplies LTIM, AEOI, the vector base and the mask.

## Interface
- Parameters: none. The request width is fixed at 8 by the 8259 architecture.
- clk  in  1  system clock; all state updates on the rising edge
- rst_n  in  1  reset, synchronous, active-low
- interrupt_request_pin  in  8  IR7..IR0, synchronous to clk
- level_or_edge_triggered  in  1  LTIM: 1 = level-sensed, 0 = edge-sensed
- interrupt_mask  in  8  IMR: 1 = masked
- auto_eoi_config  in  1  AEOI from ICW4
- interrupt_vector_base  in  5  T7–T3 from ICW2
- interrupt_acknowledge_n  in  1  INTA, active-low, synchronous to clk
- eoi_nonspecific  in  1  one-cycle OCW2 non-specific EOI
- eoi_specific  in  1  one-cycle OCW2 specific EOI of eoi_level
- rotate_on_eoi  in  1  qualifies either EOI: rotate priority to the cleared level
- set_priority  in  1  one-cycle OCW2 set-priority: lowest priority <= eoi_level
- eoi_level  in  3  L2–L0
- interrupt_to_cpu  out  1  INT
- vector_out  out  8  {interrupt_vector_base, level}
- vector_valid  out  1  vector_out drive-enable for the data bus
- interrupt_request_register  out  8  IRR, for OCW3 status reads
- in_service_register  out  8  ISR, for OCW3 status reads

## Operation
- Reset values:
  - IRR = 0, ISR = 0.
  - lowest_priority = 7, so IR0 is highest priority.
  - ir_q = 8'hFF.
  - State = IDLE.
  - interrupt_to_cpu = 0, vector_out = 0, vector_valid = 0.
- IRR capture (per bit i, each edge):
  - Edge mode: the bit sets when pin & ~ir_q.
  - Level mode: the bit sets when the pin is high.
  - Both modes: the bit clears when the pin is low, or when bit i is acknowledged.
  - ir_q <= pin on every edge. Because ir_q resets to 1s, a line already high at reset exit is not an edge.
- Priority order: lowest_priority+1 (highest) through lowest_priority (lowest), modulo 8.
- Request set = IRR & ~interrupt_mask. The winner is the highest-priority member of the set.
- interrupt_to_cpu is a register. It is set when a winner exists and outranks every ISR bit (strictly higher). It is forced to 0 in ACK1 and ACK2.
- FSM states IDLE, ACK1, ACK2. Falling edge = inta_q & ~interrupt_acknowledge_n; rising edge is the inverse.
  - IDLE, falling edge with a winner: ISR[w] <= 1, IRR[w] <= 0, level <= w, go to ACK1.
  - IDLE, falling edge with no winner (spurious): level <= 7, ISR unchanged, go to ACK1.
  - ACK1, falling edge: vector_out <= {base, level}, vector_valid <= 1, go to ACK2.
  - ACK2, rising edge: vector_valid <= 0, go to IDLE.
  - On that ACK2 exit with AEOI, ISR[level] <= 0. This is skipped for a spurious acknowledge.
- Non-specific EOI clears the highest-priority set ISR bit. With no ISR bit set, nothing changes.
- Specific EOI clears ISR[eoi_level].
- rotate_on_eoi with an EOI sets lowest_priority to the cleared level.
- set_priority sets lowest_priority <= eoi_level.
- Simultaneous events:
  - EOI is evaluated on the pre-edge ISR.
  - An ISR set in the same cycle wins on the same bit.
  - set_priority combined with a rotating EOI: set_priority wins.

## Timing
- Pin rises before edge k: IRR[i] = 1 after edge k; interrupt_to_cpu = 1 after edge k+1.
- First INTA falling edge sampled at edge m: ISR set, IRR cleared, interrupt_to_cpu = 0 after edge m.
- vector_valid is high from the edge after the second falling edge until the edge that samples INTA high.
- INTA low and high phases are each at least 1 clk.
- EOI: ISR clears after the pulse edge. interrupt_to_cpu re-evaluates one edge later.
- rst_n low at any point, including mid-INTA, returns every output to its reset value after that edge.

## Test plan
- Edge mode, base 5'b01000, IR3 rises: IRR = 8'h08 after 1 edge, INT after 2. Two INTA pulses give ISR = 8'h08, vector_out = 8'h43 with vector_valid only during the second pulse. IR3 held high does not re-request.
- IR5 in service, IR2 and IR6 pending: INT asserts and INTA grants IR2 (ISR = 8'h24). Non-specific EOI clears bit 2 (ISR = 8'h20). IR6 stays blocked until a specific EOI on 5.
- AEOI = 1 with IR1: after the second INTA rising edge, ISR = 8'h00 and IRR = 8'h00.
- Rotation: ISR = 8'h10, non-specific EOI with rotate_on_eoi, then IR4 and IR5 requested together. IR5 is granted (lowest_priority = 4).
- Spurious: IR2 drops after INT, before INTA. vector_out = {base,3'b111}, ISR stays 8'h00.
- Mask and reset: IMR = 8'hFF with IR0 high leaves INT = 0 and IRR = 8'h01. rst_n low during ACK2 clears vector_valid and ISR after 1 edge.

Source files
------------

// File: rtl/interrupt_priority_sequencer.sv
// rtl/interrupt_priority_sequencer.sv - 8259 IRR/ISR arbitration, INTA sequencing and EOI handling
module interrupt_priority_sequencer (
    input  logic       clk,
    input  logic       rst_n,
    input  logic [7:0] interrupt_request_pin,
    input  logic       level_or_edge_triggered,
    input  logic [7:0] interrupt_mask,
    input  logic       auto_eoi_config,
    input  logic [4:0] interrupt_vector_base,
    input  logic       interrupt_acknowledge_n,
    input  logic       eoi_nonspecific,
    input  logic       eoi_specific,
    input  logic       rotate_on_eoi,
    input  logic       set_priority,
    input  logic [2:0] eoi_level,
    output logic       interrupt_to_cpu,
    output logic [7:0] vector_out,
    output logic       vector_valid,
    output logic [7:0] interrupt_request_register,
    output logic [7:0] in_service_register
);

    typedef enum logic [1:0] {IDLE, ACK1, ACK2} state_t;

    state_t     state, state_next;
    logic [7:0] ir_q, irr, isr, irr_next, isr_next, request_set;
    logic [2:0] lowest_priority, level;
    logic       inta_q, spurious;
    logic       inta_fall, inta_rise;
    logic       winner_found, isr_found, outranks;
    logic [2:0] winner, isr_top, scan_idx, winner_rank, isr_rank;
    logic       ack_take, ack_spurious, vector_load, vector_drop, aeoi_clear;
    logic       eoi_clear_valid;
    logic [2:0] eoi_clear_level;

    assign interrupt_request_register = irr;
    assign in_service_register        = isr;
    assign request_set = irr & ~interrupt_mask;
    assign inta_fall   = inta_q & ~interrupt_acknowledge_n;
    assign inta_rise   = ~inta_q & interrupt_acknowledge_n;

    // Scan from lowest to highest priority so the last hit is the highest-priority one
    always_comb begin
        winner_found = 1'b0;
        winner       = 3'd0;
        isr_found    = 1'b0;
        isr_top      = 3'd0;
        scan_idx     = 3'd0;
        for (int k = 7; k >= 0; k--) begin
            scan_idx = lowest_priority + 3'(k) + 3'd1;
            if (request_set[scan_idx]) begin
                winner_found = 1'b1;
                winner       = scan_idx;
            end
            if (isr[scan_idx]) begin
                isr_found = 1'b1;
                isr_top   = scan_idx;
            end
        end
    end

    // Rank 0 is highest priority; a request must strictly outrank the top in-service level
    always_comb begin
        winner_rank = winner - lowest_priority - 3'd1;
        isr_rank    = isr_top - lowest_priority - 3'd1;
        outranks    = winner_found && (!isr_found || (winner_rank < isr_rank));
    end

    // INTA sequencing: next state and one-cycle action strobes
    always_comb begin
        state_next   = state;
        ack_take     = 1'b0;
        ack_spurious = 1'b0;
        vector_load  = 1'b0;
        vector_drop  = 1'b0;
        case (state)
            IDLE: if (inta_fall) begin
                state_next = ACK1;
                if (winner_found) ack_take = 1'b1;
                else              ack_spurious = 1'b1;
            end
            ACK1: if (inta_fall) begin
                state_next  = ACK2;
                vector_load = 1'b1;
            end
            ACK2: if (inta_rise) begin
                state_next  = IDLE;
                vector_drop = 1'b1;
            end
            default: state_next = IDLE;
        endcase
    end

    assign aeoi_clear = vector_drop & auto_eoi_config & ~spurious;

    // Select which ISR level an OCW2 EOI clears, judged on the pre-edge ISR
    always_comb begin
        eoi_clear_valid = 1'b0;
        eoi_clear_level = eoi_level;
        if (eoi_specific) begin
            eoi_clear_valid = 1'b1;
        end else if (eoi_nonspecific && isr_found) begin
            eoi_clear_valid = 1'b1;
            eoi_clear_level = isr_top;
        end
    end

    // Next IRR/ISR: clears first, then sets so a same-cycle ISR set wins
    always_comb begin
        isr_next = isr;
        if (eoi_clear_valid) isr_next[eoi_clear_level] = 1'b0;
        if (aeoi_clear)      isr_next[level] = 1'b0;
        if (ack_take)        isr_next[winner] = 1'b1;
        irr_next = irr;
        for (int i = 0; i < 8; i++) begin
            if (level_or_edge_triggered ? interrupt_request_pin[i]
                                        : (interrupt_request_pin[i] & ~ir_q[i]))
                irr_next[i] = 1'b1;
            if (!interrupt_request_pin[i] || (ack_take && (winner == 3'(i))))
                irr_next[i] = 1'b0;
        end
    end

    // FSM state register
    always_ff @(posedge clk) begin
        if (!rst_n) state <= IDLE;
        else        state <= state_next;
    end

    // Request/service registers, priority rotation, INT and vector outputs
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            ir_q             <= 8'hFF;
            inta_q           <= 1'b1;
            irr              <= 8'h00;
            isr              <= 8'h00;
            lowest_priority  <= 3'd7;
            level            <= 3'd0;
            spurious         <= 1'b0;
            interrupt_to_cpu <= 1'b0;
            vector_out       <= 8'h00;
            vector_valid     <= 1'b0;
        end else begin
            ir_q             <= interrupt_request_pin;
            inta_q           <= interrupt_acknowledge_n;
            irr              <= irr_next;
            isr              <= isr_next;
            interrupt_to_cpu <= (state_next == IDLE) && outranks;
            if (ack_take) begin
                level    <= winner;
                spurious <= 1'b0;
            end else if (ack_spurious) begin
                level    <= 3'd7;
                spurious <= 1'b1;
            end
            if (vector_load) begin
                vector_out   <= {interrupt_vector_base, level};
                vector_valid <= 1'b1;
            end else if (vector_drop) begin
                vector_valid <= 1'b0;
            end
            if (set_priority)
                lowest_priority <= eoi_level;
            else if (rotate_on_eoi && eoi_clear_valid)
                lowest_priority <= eoi_clear_level;
        end
    end

endmodule

// File: tb/tb_interrupt_priority_sequencer.sv
// tb/tb_interrupt_priority_sequencer.sv - scoreboard bench for interrupt_priority_sequencer
module tb_interrupt_priority_sequencer;

    logic       clk = 1'b0;
    logic       rst_n;
    logic [7:0] pin;
    logic       ltim;
    logic [7:0] mask;
    logic       aeoi;
    logic [4:0] base;
    logic       inta_n;
    logic       eoi_ns, eoi_sp, rot, setp;
    logic [2:0] lvl;
    logic       int_cpu;
    logic [7:0] vec;
    logic       vv;
    logic [7:0] irr, isr;

    int checks = 0;
    int errors = 0;
    logic [7:0] exp_q[$];
    logic       vv_q = 1'b0;

    always #5 clk = ~clk;

    interrupt_priority_sequencer dut (
        .clk                        (clk),
        .rst_n                      (rst_n),
        .interrupt_request_pin      (pin),
        .level_or_edge_triggered    (ltim),
        .interrupt_mask             (mask),
        .auto_eoi_config            (aeoi),
        .interrupt_vector_base      (base),
        .interrupt_acknowledge_n    (inta_n),
        .eoi_nonspecific            (eoi_ns),
        .eoi_specific               (eoi_sp),
        .rotate_on_eoi              (rot),
        .set_priority               (setp),
        .eoi_level                  (lvl),
        .interrupt_to_cpu           (int_cpu),
        .vector_out                 (vec),
        .vector_valid               (vv),
        .interrupt_request_register (irr),
        .in_service_register        (isr)
    );

    // Monitor: each new vector_valid assertion is compared with the oldest expected vector
    always @(negedge clk) begin
        if (vv === 1'b1 && vv_q !== 1'b1) begin
            checks++;
            if (exp_q.size() == 0) begin
                errors++;
                $display("FAIL vector_unexpected: got %h required none", vec);
            end else begin
                logic [7:0] e;
                e = exp_q.pop_front();
                if (vec !== e) begin
                    errors++;
                    $display("FAIL vector: got %h required %h", vec, e);
                end
            end
        end
        vv_q = vv;
    end

    task automatic tick(input int n = 1);
        repeat (n) @(negedge clk);
    endtask

    task automatic chk(input string name, input logic [7:0] got, input logic [7:0] want);
        checks++;
        if (got !== want) begin
            errors++;
            $display("FAIL %s: got %h required %h", name, got, want);
        end
    endtask

    task automatic inta_cycle(input string name, input logic [7:0] isr_exp, input logic [7:0] vec_exp);
        inta_n = 1'b0; tick();
        chk({name, "_ack1_isr"}, isr, isr_exp);
        chk({name, "_ack1_int"}, {7'd0, int_cpu}, 8'h00);
        chk({name, "_ack1_vv"}, {7'd0, vv}, 8'h00);
        inta_n = 1'b1; tick();
        exp_q.push_back(vec_exp);
        inta_n = 1'b0; tick();
        chk({name, "_ack2_vv"}, {7'd0, vv}, 8'h01);
        inta_n = 1'b1; tick();
        chk({name, "_exit_vv"}, {7'd0, vv}, 8'h00);
    endtask

    task automatic pulse_eoi(input logic ns, input logic sp, input logic r, input logic [2:0] l);
        eoi_ns = ns; eoi_sp = sp; rot = r; lvl = l;
        tick();
        eoi_ns = 1'b0; eoi_sp = 1'b0; rot = 1'b0;
    endtask

    initial begin
        rst_n = 1'b0; pin = 8'h00; ltim = 1'b0; mask = 8'h00; aeoi = 1'b0;
        base = 5'b01000; inta_n = 1'b1; eoi_ns = 1'b0; eoi_sp = 1'b0;
        rot = 1'b0; setp = 1'b0; lvl = 3'd0;
        tick(2);
        chk("rst_irr", irr, 8'h00);
        chk("rst_isr", isr, 8'h00);
        chk("rst_int", {7'd0, int_cpu}, 8'h00);
        chk("rst_vec", vec, 8'h00);
        chk("rst_vv", {7'd0, vv}, 8'h00);
        rst_n = 1'b1; tick();

        // Edge mode IR3: IRR after 1 edge, INT after 2, vector 0x43, no re-request while held
        pin = 8'h08; tick();
        chk("t1_irr", irr, 8'h08);
        chk("t1_int_early", {7'd0, int_cpu}, 8'h00);
        tick();
        chk("t1_int", {7'd0, int_cpu}, 8'h01);
        inta_cycle("t1", 8'h08, 8'h43);
        tick(2);
        chk("t1_held_irr", irr, 8'h00);
        chk("t1_held_int", {7'd0, int_cpu}, 8'h00);
        chk("t1_isr", isr, 8'h08);
        pin = 8'h00;
        pulse_eoi(1'b0, 1'b1, 1'b0, 3'd3);
        chk("t1_eoi_isr", isr, 8'h00);

        // IR5 in service, IR2 and IR6 pending
        pin = 8'h20; tick(2);
        inta_cycle("t2a", 8'h20, 8'h45);
        pin = 8'h44; tick();
        chk("t2_irr", irr, 8'h44);
        tick();
        chk("t2_int", {7'd0, int_cpu}, 8'h01);
        inta_cycle("t2b", 8'h24, 8'h42);
        chk("t2_irr_after", irr, 8'h40);
        pulse_eoi(1'b1, 1'b0, 1'b0, 3'd0);
        chk("t2_ns_eoi_isr", isr, 8'h20);
        tick(2);
        chk("t2_ir6_blocked", {7'd0, int_cpu}, 8'h00);
        pulse_eoi(1'b0, 1'b1, 1'b0, 3'd5);
        chk("t2_sp_eoi_isr", isr, 8'h00);
        chk("t2_int_lag", {7'd0, int_cpu}, 8'h00);
        tick();
        chk("t2_int_ir6", {7'd0, int_cpu}, 8'h01);
        inta_cycle("t2c", 8'h40, 8'h46);
        pin = 8'h00;
        pulse_eoi(1'b0, 1'b1, 1'b0, 3'd6);
        chk("t2_isr_clear", isr, 8'h00);

        // AEOI with IR1
        aeoi = 1'b1; pin = 8'h02; tick(2);
        inta_cycle("t3", 8'h02, 8'h41);
        chk("t3_aeoi_isr", isr, 8'h00);
        chk("t3_aeoi_irr", irr, 8'h00);
        aeoi = 1'b0; pin = 8'h00; tick();

        // Rotation: EOI+rotate on level 4 makes IR5 highest
        pin = 8'h10; tick(2);
        inta_cycle("t4a", 8'h10, 8'h44);
        pin = 8'h00;
        pulse_eoi(1'b1, 1'b0, 1'b1, 3'd0);
        chk("t4_rot_isr", isr, 8'h00);
        pin = 8'h30; tick();
        chk("t4_irr", irr, 8'h30);
        tick();
        chk("t4_int", {7'd0, int_cpu}, 8'h01);
        inta_cycle("t4b", 8'h20, 8'h45);
        chk("t4_irr_after", irr, 8'h10);
        pulse_eoi(1'b1, 1'b0, 1'b0, 3'd0);
        tick();
        chk("t4_int_ir4", {7'd0, int_cpu}, 8'h01);
        inta_cycle("t4c", 8'h10, 8'h44);
        pin = 8'h00;
        pulse_eoi(1'b0, 1'b1, 1'b0, 3'd4);
        setp = 1'b1; lvl = 3'd7; tick(); setp = 1'b0;
        chk("t4_isr_clear", isr, 8'h00);

        // Spurious: IR2 withdrawn after INT, before INTA
        pin = 8'h04; tick(2);
        chk("t5_int", {7'd0, int_cpu}, 8'h01);
        pin = 8'h00; tick();
        chk("t5_irr_drop", irr, 8'h00);
        inta_cycle("t5", 8'h00, 8'h47);
        chk("t5_isr", isr, 8'h00);

        // Mask, then reset in the middle of ACK2
        mask = 8'hFF; pin = 8'h01; tick(2);
        chk("t6_masked_irr", irr, 8'h01);
        chk("t6_masked_int", {7'd0, int_cpu}, 8'h00);
        mask = 8'h00; tick();
        chk("t6_unmasked_int", {7'd0, int_cpu}, 8'h01);
        inta_n = 1'b0; tick();
        chk("t6_ack1_isr", isr, 8'h01);
        inta_n = 1'b1; tick();
        exp_q.push_back(8'h40);
        inta_n = 1'b0; tick();
        chk("t6_ack2_vv", {7'd0, vv}, 8'h01);
        rst_n = 1'b0; tick();
        chk("t6_rst_vv", {7'd0, vv}, 8'h00);
        chk("t6_rst_isr", isr, 8'h00);
        chk("t6_rst_vec", vec, 8'h00);
        chk("t6_rst_int", {7'd0, int_cpu}, 8'h00);
        chk("t6_rst_irr", irr, 8'h00);
        rst_n = 1'b1; inta_n = 1'b1; tick(2);
        chk("t6_high_at_exit_irr", irr, 8'h00);
        ltim = 1'b1; tick();
        chk("t6_level_irr", irr, 8'h01);
        tick();
        chk("t6_level_int", {7'd0, int_cpu}, 8'h01);

        tick(2);
        chk("queue_empty", 8'(exp_q.size()), 8'h00);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
